score_bcd_keeper: RTL and testbench
===================================

Name: score_bcd_keeper

Overview:
Sequential BCD score engine with a parametrised digit count. It replaces combinational divide/modulo score splitting in the top level. It accepts binary point increments over a valid/ready handshake, converts them to BCD by serial double-dabble, and ripples a BCD add one digit per cycle. It also keeps a high score, saturates at all-9s, and drives registered active-low 7-segment patterns with leading-zero blanking for the HEX displays.

Parameters:
NUM_DIGITS, 4, number of BCD digits held and displayed (2..8)
AMT_W, 8, width of binary increment (1..16); elaboration error unless 2^AMT_W-1 < 10^NUM_DIGITS

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous score clear (game restart); high score retained
add_valid  in  1  increment request
add_amount  in  AMT_W  binary points to add
add_ready  out  1  increment accepted when add_valid && add_ready
busy  out  1  conversion/add in progress
saturated  out  1  sticky; score clamped at all-9s
new_high  out  1  one-cycle pulse when high score is replaced
show_high  in  1  display select: 0 = score, 1 = high score
score_bcd  out  4*NUM_DIGITS  current score, digit 0 in [3:0]
high_bcd  out  4*NUM_DIGITS  high score
seg_out  out  8*NUM_DIGITS  active-low {dp,g,f,e,d,c,b,a} per digit, digit 0 in [7:0]

Behaviour:
- Reset (Reset_n=0, async) sets:
  - score_bcd=0, high_bcd=0, saturated=0, new_high=0, busy=0, FSM=IDLE.
  - seg_out: digit0=8'hC0, all other digits 8'hFF.
- add_ready = (state==IDLE) && !clear. It is combinational, so it is 1 after reset whenever clear=0.
- FSM: IDLE -> CONV -> ADD -> COMMIT -> IDLE.
  - IDLE: on accept, latch add_amount and go to CONV. If saturated=1, the request is accepted and dropped; the FSM stays in IDLE.
  - CONV: exactly AMT_W cycles of double-dabble (add 3 to any nibble >=5, then shift left 1) into an internal BCD operand.
  - ADD: exactly NUM_DIGITS cycles, LSD first, one digit per cycle.
    - digit sum = score digit + operand digit + carry; if sum >9, subtract 10 and carry=1.
    - Results go into an internal working register; score_bcd is not modified during ADD.
  - COMMIT: 1 cycle.
    - If the final carry out of the MSD is 1: score_bcd := all 9s and saturated := 1.
    - Otherwise score_bcd := working value.
    - On the same edge, if the new score > high_bcd (strictly): high_bcd := new score and new_high=1 for exactly one cycle.
- Latency: accept edge T; score_bcd/high_bcd update on edge T+AMT_W+NUM_DIGITS+1 (13 for defaults). add_ready is 1 in the following cycle.
- busy=1 in CONV, ADD and COMMIT.
- add_amount=0: full sequence runs, score unchanged, no new_high pulse.
- clear:
  - In any state it forces FSM=IDLE, aborts any pending add (discarded), and sets score_bcd=0 and saturated=0.
  - high_bcd is unchanged.
  - clear and add_valid in the same cycle: clear wins and the add is not accepted.
- Display:
  - Source digits are score_bcd when show_high=0, else high_bcd.
  - seg_out is registered: 1-cycle latency from any change of the source or show_high.
  - Leading-zero blanking: a digit is blank (8'hFF) if it and all higher digits are 0. Digit 0 is never blanked.
  - dp is always 1 (off).
  - Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.

Test Plan:
1. Reset check: assert Reset_n=0 mid-operation, then release.
   - score_bcd=0, high_bcd=0, busy=0, saturated=0.
   - seg_out={FF,FF,FF,C0}; add_ready=1 one cycle after release.
2. Two adds: add 7, then add 5.
   - score_bcd=16'h0012 exactly 13 edges after the second accept.
   - add_ready=0 and busy=1 for those 13 cycles.
   - new_high pulses once per add; high_bcd=16'h0012.
3. Carry ripple: from score 0999, add 1.
   - score_bcd=16'h1000; saturated=0.
4. Saturation: from 9990, add 255.
   - score_bcd=16'h9999, saturated=1.
   - A further add of 3 gets add_ready=1 with no busy cycle; score stays 9999.
5. Clear mid-ADD: score 0050, high 0050, add 200, clear asserted during ADD.
   - score_bcd=0, FSM IDLE next cycle, high_bcd=16'h0050, no new_high.
   - clear+add_valid in the same cycle: add not accepted.
6. Display: score 0042.
   - seg_out={FF,FF,99,A4} one cycle later.
   - Set show_high=1 with high 0150: seg_out={FF,F9,92,C0} after one cycle.

Source files
------------

// File: rtl/score_bcd_keeper.sv
// BCD score keeper: serial binary-to-BCD conversion of each increment, digit-serial
// BCD add into the running score, high-score tracking with saturation at all-9s,
// and registered active-low 7-segment drive with leading-zero blanking.
module score_bcd_keeper #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned AMT_W      = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    clear,
  input  logic                    add_valid,
  input  logic [AMT_W-1:0]        add_amount,
  output logic                    add_ready,
  output logic                    busy,
  output logic                    saturated,
  output logic                    new_high,
  input  logic                    show_high,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic [8*NUM_DIGITS-1:0] seg_out
);

  localparam int unsigned BcdW   = 4 * NUM_DIGITS;
  localparam int unsigned SegW   = 8 * NUM_DIGITS;
  localparam int unsigned CntMax = (AMT_W > NUM_DIGITS) ? AMT_W : NUM_DIGITS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ConvLast = CntW'(AMT_W - 1);
  localparam logic [CntW-1:0] AddLast  = CntW'(NUM_DIGITS - 1);
  localparam logic [BcdW-1:0] AllNines = {NUM_DIGITS{4'h9}};
  localparam logic [SegW-1:0] SegReset = {{(NUM_DIGITS - 1){8'hFF}}, 8'hC0};

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned k = 0; k < n; k++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // Reject parameter sets where the largest increment cannot be represented in BCD.
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("score_bcd_keeper: NUM_DIGITS must be in 2..8");
  end
  if (AMT_W < 1 || AMT_W > 16) begin : g_bad_amt_w
    $error("score_bcd_keeper: AMT_W must be in 1..16");
  end
  if (((64'd1 << AMT_W) - 64'd1) >= pow10(NUM_DIGITS)) begin : g_bad_range
    $error("score_bcd_keeper: 2^AMT_W-1 must be below 10^NUM_DIGITS");
  end

  typedef enum logic [1:0] {StIdle, StConv, StAdd, StCommit} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [BcdW-1:0]   opnd_q, opnd_d;
  logic [BcdW-1:0]   work_q, work_d;
  logic              carry_q, carry_d;
  logic [BcdW-1:0]   score_q, score_d;
  logic [BcdW-1:0]   high_q, high_d;
  logic              sat_q, sat_d;
  logic              new_high_q, new_high_d;
  logic [SegW-1:0]   seg_q, seg_d;

  logic [BcdW-1:0]   dd_adj;
  logic [3:0]        sc_dig;
  logic [3:0]        op_dig;
  logic [4:0]        dsum;
  logic [3:0]        res_dig;
  logic              res_carry;
  logic [BcdW-1:0]   commit_val;

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Double-dabble correction: add 3 to every operand nibble that is 5 or more.
  always_comb begin
    dd_adj = opnd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (opnd_q[4*i +: 4] >= 4'd5) begin
        dd_adj[4*i +: 4] = opnd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // One BCD digit of score + operand + carry, digit selected by the add counter.
  always_comb begin
    sc_dig = 4'd0;
    op_dig = 4'd0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (cnt_q == CntW'(i)) begin
        sc_dig = score_q[4*i +: 4];
        op_dig = opnd_q[4*i +: 4];
      end
    end
    dsum = {1'b0, sc_dig} + {1'b0, op_dig} + {4'd0, carry_q};
    if (dsum > 5'd9) begin
      res_dig   = 4'(dsum - 5'd10);
      res_carry = 1'b1;
    end else begin
      res_dig   = dsum[3:0];
      res_carry = 1'b0;
    end
    commit_val = carry_q ? AllNines : work_q;
  end

  // Next-state and datapath updates; clear overrides everything except the high score.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    amt_d      = amt_q;
    opnd_d     = opnd_q;
    work_d     = work_q;
    carry_d    = carry_q;
    score_d    = score_q;
    high_d     = high_q;
    sat_d      = sat_q;
    new_high_d = 1'b0;

    if (clear) begin
      state_d = StIdle;
      score_d = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A saturated score swallows the request without starting a conversion.
          if (add_valid && !sat_q) begin
            state_d = StConv;
            amt_d   = add_amount;
            opnd_d  = '0;
            cnt_d   = '0;
          end
        end
        StConv: begin
          opnd_d = {dd_adj[BcdW-2:0], amt_q[AMT_W-1]};
          amt_d  = amt_q << 1;
          if (cnt_q == ConvLast) begin
            state_d = StAdd;
            cnt_d   = '0;
            carry_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StAdd: begin
          for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (cnt_q == CntW'(i)) begin
              work_d[4*i +: 4] = res_dig;
            end
          end
          carry_d = res_carry;
          if (cnt_q == AddLast) begin
            state_d = StCommit;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCommit: begin
          score_d = commit_val;
          sat_d   = sat_q | carry_q;
          // BCD digit order preserves numeric order, so a plain compare suffices.
          if (commit_val > high_q) begin
            high_d     = commit_val;
            new_high_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Display encode: blank a digit only while it and every higher digit are zero.
  always_comb begin
    logic [BcdW-1:0] src;
    logic            nz;
    src   = show_high ? high_q : score_q;
    nz    = 1'b0;
    seg_d = '1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nz = nz | (src[4*i +: 4] != 4'd0);
      if (nz || i == 0) begin
        seg_d[8*i +: 8] = seg_encode(src[4*i +: 4]);
      end else begin
        seg_d[8*i +: 8] = 8'hFF;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      amt_q      <= '0;
      opnd_q     <= '0;
      work_q     <= '0;
      carry_q    <= 1'b0;
      score_q    <= '0;
      high_q     <= '0;
      sat_q      <= 1'b0;
      new_high_q <= 1'b0;
      seg_q      <= SegReset;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      amt_q      <= amt_d;
      opnd_q     <= opnd_d;
      work_q     <= work_d;
      carry_q    <= carry_d;
      score_q    <= score_d;
      high_q     <= high_d;
      sat_q      <= sat_d;
      new_high_q <= new_high_d;
      seg_q      <= seg_d;
    end
  end

  // Output drive.
  always_comb begin
    add_ready = (state_q == StIdle) && !clear;
    busy      = (state_q != StIdle);
    saturated = sat_q;
    new_high  = new_high_q;
    score_bcd = score_q;
    high_bcd  = high_q;
    seg_out   = seg_q;
  end

endmodule

// File: tb/tb_score_bcd_keeper.sv
// Self-checking bench for score_bcd_keeper: directed vector table, multi-cycle
// clear/reset/display sequences, and randomized adds against a decimal score model.
module tb_score_bcd_keeper;

  localparam int ND = 4;
  localparam int AW = 8;
  localparam int MaxScore = 9999;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            clear = 1'b0;
  logic            add_valid = 1'b0;
  logic [AW-1:0]   add_amount = '0;
  logic            show_high = 1'b0;
  logic            add_ready;
  logic            busy;
  logic            saturated;
  logic            new_high;
  logic [4*ND-1:0] score_bcd;
  logic [4*ND-1:0] high_bcd;
  logic [8*ND-1:0] seg_out;

  score_bcd_keeper #(
    .NUM_DIGITS(ND),
    .AMT_W     (AW)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .clear     (clear),
    .add_valid (add_valid),
    .add_amount(add_amount),
    .add_ready (add_ready),
    .busy      (busy),
    .saturated (saturated),
    .new_high  (new_high),
    .show_high (show_high),
    .score_bcd (score_bcd),
    .high_bcd  (high_bcd),
    .seg_out   (seg_out)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: plain decimal integers.
  int m_score = 0;
  int m_high = 0;
  bit m_sat = 1'b0;
  bit last_pulse = 1'b0;

  typedef struct {
    int amt;
    int exp_score;
    bit exp_sat;
    bit exp_pulse;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < ND; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [8*ND-1:0] exp_seg(input int v);
    logic [7:0] codes [10];
    logic [8*ND-1:0] r;
    int p;
    codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    p = 1;
    for (int d = 0; d < ND; d++) begin
      if (d > 0 && v < p) r[8*d +: 8] = 8'hFF;
      else r[8*d +: 8] = codes[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic bit model_add(input int amt);
    int s;
    if (m_sat) return 1'b0;
    s = m_score + amt;
    if (s > MaxScore) begin
      s = MaxScore;
      m_sat = 1'b1;
    end
    m_score = s;
    if (s > m_high) begin
      m_high = s;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Called at a negedge: pulse reset, check reset values, release, check readiness.
  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    chk("rst_score", score_bcd, 0);
    chk("rst_high", high_bcd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", saturated, 0);
    chk("rst_new_high", new_high, 0);
    chk("rst_seg", seg_out, 32'hFFFF_FFC0);
    @(negedge Clk);
    Reset_n = 1'b1;
    m_score = 0;
    m_high = 0;
    m_sat = 1'b0;
    @(negedge Clk);
    chk("rst_ready_after_release", add_ready, 1);
  endtask

  // Called at a negedge while idle. clr_at >= 0 asserts clear that many cycles after accept.
  task automatic run_add(input int amt, input int clr_at);
    int old_score;
    int old_high;
    bit was_sat;
    bit pulse;
    int bad;
    old_score = m_score;
    old_high = m_high;
    was_sat = m_sat;
    bad = 0;
    chk("ready_before_add", add_ready, 1);
    add_valid = 1'b1;
    add_amount = AW'(amt);
    @(posedge Clk);
    @(negedge Clk);
    add_valid = 1'b0;
    add_amount = '0;
    if (was_sat) begin
      last_pulse = new_high;
      chk("sat_drop_busy", busy, 0);
      chk("sat_drop_ready", add_ready, 1);
      chk("sat_drop_score", score_bcd, to_bcd(old_score));
      return;
    end
    if (clr_at >= 0) begin
      for (int i = 0; i < clr_at; i++) begin
        if (busy !== 1'b1 || add_ready !== 1'b0) bad++;
        @(negedge Clk);
      end
      clear = 1'b1;
      #1;
      chk("ready_low_during_clear", add_ready, 0);
      @(negedge Clk);
      clear = 1'b0;
      m_score = 0;
      m_sat = 1'b0;
      chk("clr_busy_window", bad, 0);
      chk("clr_busy", busy, 0);
      chk("clr_score", score_bcd, 0);
      chk("clr_high_kept", high_bcd, to_bcd(old_high));
      chk("clr_sat", saturated, 0);
      chk("clr_no_new_high", new_high, 0);
      return;
    end
    pulse = model_add(amt);
    for (int i = 0; i < AW + ND + 1; i++) begin
      if (busy !== 1'b1 || add_ready !== 1'b0 || new_high !== 1'b0 ||
          score_bcd !== to_bcd(old_score)) bad++;
      @(negedge Clk);
    end
    last_pulse = new_high;
    chk("busy_window", bad, 0);
    chk("commit_score", score_bcd, to_bcd(m_score));
    chk("commit_high", high_bcd, to_bcd(m_high));
    chk("commit_sat", saturated, m_sat);
    chk("new_high_pulse", new_high, pulse);
    chk("ready_after_commit", add_ready, 1);
    @(negedge Clk);
    chk("new_high_one_cycle", new_high, 0);
    chk("seg_after_commit", seg_out, exp_seg(show_high ? m_high : m_score));
  endtask

  initial begin
    // Directed table: 7, 5, 0, ripple to 999, carry to 1000, climb to 9990, saturate.
    vecs.push_back('{7, 7, 1'b0, 1'b1});
    vecs.push_back('{5, 12, 1'b0, 1'b1});
    vecs.push_back('{0, 12, 1'b0, 1'b0});
    vecs.push_back('{255, 267, 1'b0, 1'b1});
    vecs.push_back('{255, 522, 1'b0, 1'b1});
    vecs.push_back('{255, 777, 1'b0, 1'b1});
    vecs.push_back('{222, 999, 1'b0, 1'b1});
    vecs.push_back('{1, 1000, 1'b0, 1'b1});
    for (int i = 1; i <= 35; i++) vecs.push_back('{255, 1000 + 255 * i, 1'b0, 1'b1});
    vecs.push_back('{65, 9990, 1'b0, 1'b1});
    vecs.push_back('{255, 9999, 1'b1, 1'b1});
    vecs.push_back('{3, 9999, 1'b1, 1'b0});

    @(negedge Clk);
    do_reset();

    // Reset in the middle of a conversion.
    add_valid = 1'b1;
    add_amount = 8'd100;
    @(posedge Clk);
    @(negedge Clk);
    add_valid = 1'b0;
    repeat (5) @(negedge Clk);
    chk("busy_before_midop_reset", busy, 1);
    do_reset();

    foreach (vecs[k]) begin
      run_add(vecs[k].amt, -1);
      chk("vec_score", score_bcd, to_bcd(vecs[k].exp_score));
      chk("vec_sat", saturated, vecs[k].exp_sat);
      chk("vec_pulse", last_pulse, vecs[k].exp_pulse);
    end

    // Clear during ADD, then clear racing an add request.
    do_reset();
    run_add(50, -1);
    run_add(200, AW + 2);
    chk("clr_mid_add_high", high_bcd, 16'h0050);
    clear = 1'b1;
    add_valid = 1'b1;
    add_amount = 8'd9;
    @(posedge Clk);
    @(negedge Clk);
    clear = 1'b0;
    add_valid = 1'b0;
    chk("clear_wins_busy", busy, 0);
    chk("clear_wins_score", score_bcd, 0);
    @(negedge Clk);
    chk("clear_wins_still_idle", busy, 0);

    // Display: blanking, show_high select and one-cycle latency.
    do_reset();
    run_add(42, -1);
    chk("seg_42", seg_out, 32'hFFFF_99A4);
    run_add(108, -1);
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    m_score = 0;
    @(negedge Clk);
    chk("seg_zero", seg_out, 32'hFFFF_FFC0);
    show_high = 1'b1;
    #1;
    chk("seg_latency", seg_out, 32'hFFFF_FFC0);
    @(negedge Clk);
    chk("seg_high_150", seg_out, 32'hFFF9_92C0);
    chk("high_150", high_bcd, 16'h0150);
    show_high = 1'b0;
    @(negedge Clk);

    // Randomized adds with occasional aborting clears.
    do_reset();
    for (int n = 0; n < 70; n++) begin
      int amt;
      int clr;
      amt = int'($urandom_range(0, 255));
      clr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, AW + ND)) : -1;
      show_high = 1'($urandom_range(0, 1));
      run_add(amt, clr);
      @(negedge Clk);
      chk("rnd_score", score_bcd, to_bcd(m_score));
      chk("rnd_high", high_bcd, to_bcd(m_high));
      chk("rnd_sat", saturated, m_sat);
      chk("rnd_seg", seg_out, exp_seg(show_high ? m_high : m_score));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
